ox_frame_sequencer: RTL and testbench

- Upstream feeder for the 16-input O/X MLP classifier.
- Deserialises a 4x4 binary pixel stream (raster order) and its label into a stable 16-bit frame.
- Waits for the classifier datapath to settle, then captures the prediction and issues a one-cycle learn pulse in training mode.
- Keeps saturating frame and correct-prediction statistics.

---
 rtl/ox_pkg.sv | 16 +
 rtl/ox_frame_sequencer_if.sv | 26 ++
 rtl/ox_sat_counter.sv | 22 ++
 rtl/ox_frame_sequencer.sv | 124 ++++++++++++
 tb/tb_ox_frame_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ox_pkg.sv
// Shared types and constants for the O/X classifier front end.
// Imported by the frame sequencer, its interface and its counters.
package ox_pkg;

    localparam int PIX_N          = 16;
    localparam int PROB_W         = 7;
    localparam int SETTLE_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_SETTLE,
        ST_EVAL,
        ST_LEARN
    } seq_state_t;

endpackage

// File: rtl/ox_frame_sequencer_if.sv
// Pixel-stream and result bundle between the frame source and the sequencer.
// The master drives pixels and consumes results; the slave is the sequencer.
interface ox_frame_sequencer_if;
    import ox_pkg::*;

    logic              pix_valid;
    logic              pix_bit;
    logic              pix_label;
    logic              train_mode;
    logic              pix_ready;
    logic              res_valid;
    logic              res_y;
    logic [PROB_W-1:0] res_prob;
    logic              res_correct;

    modport master (
        output pix_valid, pix_bit, pix_label, train_mode,
        input  pix_ready, res_valid, res_y, res_prob, res_correct
    );

    modport slave (
        input  pix_valid, pix_bit, pix_label, train_mode,
        output pix_ready, res_valid, res_y, res_prob, res_correct
    );

endinterface

// File: rtl/ox_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ox_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ox_frame_sequencer.sv
// Deserialises a 4x4 pixel frame, holds it for the classifier to settle,
// captures the prediction, strobes learn in training mode, keeps statistics.
module ox_frame_sequencer
    import ox_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    ox_frame_sequencer_if.slave seq,
    input  logic              clear_stats,
    output logic [PIX_N-1:0]  x_out,
    output logic              is_O,
    output logic              learn,
    input  logic              y_in,
    input  logic [PROB_W-1:0] prob_in,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  correct_cnt
);

    localparam int IDX_W = $clog2(PIX_N);
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    seq_state_t       state, state_next;
    logic [IDX_W-1:0] idx;
    logic [PIX_N-1:0] shreg;
    logic [SET_W-1:0] settle_cnt;
    logic             train_q;
    logic             accept;
    logic             last_pix;
    logic             settle_done;
    logic             eval_now;
    logic             hit;

    assign accept      = seq.pix_valid && seq.pix_ready;
    assign last_pix    = accept && (idx == IDX_W'(PIX_N - 1));
    assign settle_done = (settle_cnt == SET_W'(SETTLE - 1));
    assign eval_now    = (state == ST_EVAL);
    assign hit         = (y_in == is_O);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next    = state;
        seq.pix_ready = 1'b0;
        seq.res_valid = 1'b0;
        learn         = 1'b0;
        unique case (state)
            ST_COLLECT: begin
                seq.pix_ready = 1'b1;
                if (last_pix) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_done) state_next = ST_EVAL;
            end
            ST_EVAL: begin
                state_next = ST_LEARN;
            end
            ST_LEARN: begin
                seq.res_valid = 1'b1;
                learn         = train_q;
                state_next    = ST_COLLECT;
            end
            default: state_next = ST_COLLECT;
        endcase
    end

    // Pixel k lands at bit k: shift right with the newest pixel entering at the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx             <= '0;
            shreg           <= '0;
            settle_cnt      <= '0;
            train_q         <= 1'b0;
            x_out           <= '0;
            is_O            <= 1'b0;
            seq.res_y       <= 1'b0;
            seq.res_prob    <= '0;
            seq.res_correct <= 1'b0;
        end else begin
            if (accept) begin
                shreg <= {seq.pix_bit, shreg[PIX_N-1:1]};
                idx   <= last_pix ? '0 : idx + 1'b1;
            end
            if (last_pix) begin
                x_out   <= {seq.pix_bit, shreg[PIX_N-1:1]};
                is_O    <= seq.pix_label;
                train_q <= seq.train_mode;
            end
            settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (eval_now) begin
                seq.res_y       <= y_in;
                seq.res_prob    <= prob_in;
                seq.res_correct <= hit;
            end
        end
    end

    ox_sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (eval_now),
        .clear (clear_stats),
        .count (frame_cnt)
    );

    ox_sat_counter #(.CNT_W(CNT_W)) u_correct_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (eval_now && hit),
        .clear (clear_stats),
        .count (correct_cnt)
    );

endmodule

// File: tb/tb_ox_frame_sequencer.sv
// Bench for ox_frame_sequencer: table of frames, result scoreboard, reset and
// saturation corner cases (a 2-bit-counter twin runs in lockstep).
module tb_ox_frame_sequencer;
    import ox_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clear_stats;
    logic        y_in;
    logic [6:0]  prob_in;
    logic [15:0] x_out, x_out2;
    logic        is_O, is_O2, learn, learn2;
    logic [15:0] frame_cnt, correct_cnt;
    logic [1:0]  frame_cnt2, correct_cnt2;

    ox_frame_sequencer_if ifc ();
    ox_frame_sequencer_if ifc2 ();

    assign ifc2.pix_valid  = ifc.pix_valid;
    assign ifc2.pix_bit    = ifc.pix_bit;
    assign ifc2.pix_label  = ifc.pix_label;
    assign ifc2.train_mode = ifc.train_mode;

    ox_frame_sequencer #(.SETTLE(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .seq(ifc.slave), .clear_stats(clear_stats),
        .x_out(x_out), .is_O(is_O), .learn(learn), .y_in(y_in), .prob_in(prob_in),
        .frame_cnt(frame_cnt), .correct_cnt(correct_cnt)
    );

    ox_frame_sequencer #(.SETTLE(3), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .seq(ifc2.slave), .clear_stats(clear_stats),
        .x_out(x_out2), .is_O(is_O2), .learn(learn2), .y_in(y_in), .prob_in(prob_in),
        .frame_cnt(frame_cnt2), .correct_cnt(correct_cnt2)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic [15:0] pat;
        logic        label;
        logic        train;
        logic        y;
        logic [6:0]  prob;
        bit          keep_valid;
        bit          clr;
        logic        exp_correct;
    } frame_vec_t;

    typedef struct {
        logic        y;
        logic [6:0]  prob;
        logic        correct;
        logic [15:0] fc, cc;
        logic [1:0]  fc2, cc2;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_fc, m_cc;
    logic [1:0]  m_fc2, m_cc2;
    frame_vec_t  vecs[8];

    always @(negedge clk) begin
        exp_t e;
        if (!rst && ifc.res_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 32'(ifc.res_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("res_y",        32'(ifc.res_y),       32'(e.y));
                check("res_prob",     32'(ifc.res_prob),    32'(e.prob));
                check("res_correct",  32'(ifc.res_correct), 32'(e.correct));
                check("frame_cnt",    32'(frame_cnt),       32'(e.fc));
                check("correct_cnt",  32'(correct_cnt),     32'(e.cc));
                check("frame_cnt_w2", 32'(frame_cnt2),      32'(e.fc2));
                check("correct_cnt_w2", 32'(correct_cnt2),  32'(e.cc2));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_ready"}, 32'(ifc.pix_ready), 32'd1);
        check({tag, "_x_out"},     32'(x_out),         32'd0);
        check({tag, "_is_O"},      32'(is_O),          32'd0);
        check({tag, "_strobes"},   32'({learn, ifc.res_valid}), 32'd0);
        check({tag, "_results"},   32'({ifc.res_y, ifc.res_prob, ifc.res_correct}), 32'd0);
        check({tag, "_counters"},  32'({frame_cnt, correct_cnt}), 32'd0);
    endtask

    task automatic send_frame(input frame_vec_t v);
        int   n;
        exp_t e;
        y_in    = v.y;
        prob_in = v.prob;
        for (int i = 0; i < 16; i++) begin
            ifc.pix_valid  = 1'b1;
            ifc.pix_bit    = v.pat[i];
            ifc.pix_label  = (i == 15) ? v.label : ~v.label;
            ifc.train_mode = (i == 15) ? v.train : ~v.train;
            n = 0;
            @(negedge clk);
            while (!ifc.pix_ready && n < 40) begin
                n++;
                @(negedge clk);
            end
            if (i == 0) check("ready_first_pixel", 32'(n), 32'd0);
            else if (n != 0) check("ready_mid_frame", 32'(n), 32'd0);
            @(posedge clk);
            #1;
        end
        // Now in cycle t+1 after the committing pixel.
        if (v.clr) begin
            m_fc = '0; m_cc = '0; m_fc2 = '0; m_cc2 = '0;
        end else begin
            if (m_fc != 16'hFFFF) m_fc++;
            if (m_fc2 != 2'b11) m_fc2++;
            if (v.exp_correct) begin
                if (m_cc != 16'hFFFF) m_cc++;
                if (m_cc2 != 2'b11) m_cc2++;
            end
        end
        e.y = v.y; e.prob = v.prob; e.correct = v.exp_correct;
        e.fc = m_fc; e.cc = m_cc; e.fc2 = m_fc2; e.cc2 = m_cc2;
        sb.push_back(e);
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            ifc.pix_valid  = v.keep_valid;
            ifc.pix_bit    = c[0];
            ifc.pix_label  = ~v.label;
            ifc.train_mode = ~v.train;
            clear_stats    = v.clr && (c == 4);
            @(negedge clk);
            if (c == 1) begin
                check("x_out_commit", 32'(x_out), 32'(v.pat));
                check("is_O_commit",  32'(is_O),  32'(v.label));
            end
            if (c < 5) begin
                check("busy_outputs", 32'({ifc.pix_ready, ifc.res_valid, learn}), 32'd0);
            end else begin
                check("res_valid_t5", 32'(ifc.res_valid), 32'd1);
                check("learn_t5",     32'(learn),         32'(v.train));
                check("x_out_hold",   32'(x_out),         32'(v.pat));
            end
        end
        @(posedge clk);
        #1;
        clear_stats   = 1'b0;
        ifc.pix_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t rv;
        vecs[0] = '{pat:16'h9669, label:1'b1, train:1'b0, y:1'b1, prob:7'd83,  keep_valid:1'b0, clr:1'b0, exp_correct:1'b1};
        vecs[1] = '{pat:16'h9669, label:1'b1, train:1'b1, y:1'b0, prob:7'd20,  keep_valid:1'b0, clr:1'b0, exp_correct:1'b0};
        vecs[2] = '{pat:16'hF00F, label:1'b0, train:1'b0, y:1'b0, prob:7'd5,   keep_valid:1'b1, clr:1'b0, exp_correct:1'b1};
        vecs[3] = '{pat:16'h8001, label:1'b0, train:1'b1, y:1'b1, prob:7'd100, keep_valid:1'b0, clr:1'b0, exp_correct:1'b0};
        vecs[4] = '{pat:16'h0F0F, label:1'b1, train:1'b0, y:1'b1, prob:7'd77,  keep_valid:1'b0, clr:1'b0, exp_correct:1'b1};
        vecs[5] = '{pat:16'h5555, label:1'b0, train:1'b1, y:1'b0, prob:7'd42,  keep_valid:1'b1, clr:1'b0, exp_correct:1'b1};
        vecs[6] = '{pat:16'hFFFF, label:1'b1, train:1'b0, y:1'b1, prob:7'd100, keep_valid:1'b0, clr:1'b1, exp_correct:1'b1};
        vecs[7] = '{pat:16'h0000, label:1'b0, train:1'b0, y:1'b1, prob:7'd0,   keep_valid:1'b0, clr:1'b0, exp_correct:1'b0};

        m_fc = '0; m_cc = '0; m_fc2 = '0; m_cc2 = '0;
        rst = 1'b1; clear_stats = 1'b0; y_in = 1'b0; prob_in = '0;
        ifc.pix_valid = 1'b0; ifc.pix_bit = 1'b0; ifc.pix_label = 1'b0; ifc.train_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) send_frame(vecs[k]);

        // Reset after 9 accepted pixels discards the partial frame.
        for (int i = 0; i < 9; i++) begin
            ifc.pix_valid = 1'b1;
            ifc.pix_bit   = 1'b1;
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        ifc.pix_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_rst");
        rst = 1'b0;
        m_fc = '0; m_cc = '0; m_fc2 = '0; m_cc2 = '0;
        @(posedge clk);
        #1;
        rv = '{pat:16'h1234, label:1'b1, train:1'b1, y:1'b1, prob:7'd64, keep_valid:1'b0, clr:1'b0, exp_correct:1'b1};
        send_frame(rv);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
